// File: rtl/st7789_spi_responder.sv
// ST7789V3 4-wire serial responder: oversamples CS/SCL/SD/RS in the clk domain,
// frames MSB-first bytes, decodes the LCD command subset, tracks panel state and
// emits addressed RGB565 pixel writes.
// Optional macro ST7789_TIMING_CHK_EN adds a guard counter and timing_err output.
module st7789_spi_responder #(
  parameter int unsigned DISP_WIDTH   = 135,
  parameter int unsigned DISP_HEIGHT  = 240,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned GUARD_CYCLES = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_cs,
  input  logic        lcd_scl,
  input  logic        lcd_sd,
  input  logic        lcd_rs,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        param_valid,
  output logic [7:0]  param_data,
  output logic [2:0]  param_idx,
  output logic        px_valid,
  output logic [7:0]  px_x,
  output logic [7:0]  px_y,
  output logic [15:0] px_data,
  output logic        sleep_out,
  output logic        disp_on,
  output logic        inv_on,
`ifdef ST7789_TIMING_CHK_EN
  output logic        timing_err,
`endif
  output logic        frame_err
);

  localparam logic [7:0] XeRst = 8'(DISP_WIDTH);
  localparam logic [7:0] YeRst = 8'(DISP_HEIGHT);

  typedef enum logic [1:0] {StIdle, StParam, StRamwr} state_e;

  // ---------------- Input synchronisers ----------------
  logic [3:0] sync_q [SYNC_STAGES];
  logic       cs_s, scl_s, sd_s, rs_s;

  // Shift {cs, scl, sd, rs} through SYNC_STAGES flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {lcd_cs, lcd_scl, lcd_sd, lcd_rs};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {cs_s, scl_s, sd_s, rs_s} = sync_q[SYNC_STAGES-1];

  // ---------------- Byte framer ----------------
  logic       cs_prev_q, scl_prev_q, armed_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       rx_stb_q, rx_rs_q, rx_err_q;
  logic [7:0] rx_byte_q;
  logic       scl_rise, cs_rise, active, done;

  assign scl_rise = scl_s & ~scl_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  // The cycle CS rises still counts, so a byte finishing on that cycle completes.
  assign active   = armed_q & (~cs_s | cs_rise);
  assign done     = active & scl_rise & (bit_cnt_q == 3'd7);

  // Count bits, assemble bytes and flag partial bytes cut off by CS release.
  // Framing is armed only once CS has been seen high after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_prev_q  <= 1'b0;
      scl_prev_q <= 1'b0;
      armed_q    <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_stb_q   <= 1'b0;
      rx_rs_q    <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      cs_prev_q  <= cs_s;
      scl_prev_q <= scl_s;
      armed_q    <= armed_q | cs_s;
      rx_stb_q   <= done;
      rx_err_q   <= armed_q & cs_rise & ~done & (bit_cnt_q != 3'd0);
      if (done) begin
        rx_byte_q <= {shift_q, sd_s};
        rx_rs_q   <= rs_s;
      end
      if (cs_rise || !armed_q) begin
        bit_cnt_q <= '0;
      end else if (active && scl_rise) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        shift_q   <= {shift_q[5:0], sd_s};
      end
    end
  end

  // ---------------- Decoder state ----------------
  state_e      state_q, state_d;
  logic [7:0]  cmd_code_q, cmd_code_d, param_data_q, param_data_d, b1_q, b1_d;
  logic [2:0]  param_idx_q, param_idx_d, pcnt_q, pcnt_d;
  logic [7:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [7:0]  cx_q, cx_d, cy_q, cy_d, px_x_q, px_x_d, px_y_q, px_y_d;
  logic [15:0] px_data_q, px_data_d;
  logic        phase_q, phase_d, sleep_q, sleep_d, disp_q, disp_d, inv_q, inv_d;
  logic        cmd_valid_q, cmd_valid_d, param_valid_q, param_valid_d;
  logic        px_valid_q, px_valid_d, frame_err_q, frame_err_d;
  logic        guard_load;
`ifdef ST7789_TIMING_CHK_EN
  logic [15:0] guard_q, guard_d;
  logic        timing_err_q, timing_err_d;
`endif

  // Next-state decode of each completed byte.
  always_comb begin
    state_d       = state_q;
    cmd_code_d    = cmd_code_q;
    param_data_d  = param_data_q;
    param_idx_d   = param_idx_q;
    pcnt_d        = pcnt_q;
    b1_d          = b1_q;
    xs_d = xs_q; xe_d = xe_q; ys_d = ys_q; ye_d = ye_q;
    cx_d = cx_q; cy_d = cy_q;
    px_x_d        = px_x_q;
    px_y_d        = px_y_q;
    px_data_d     = px_data_q;
    phase_d       = phase_q;
    sleep_d       = sleep_q;
    disp_d        = disp_q;
    inv_d         = inv_q;
    cmd_valid_d   = 1'b0;
    param_valid_d = 1'b0;
    px_valid_d    = 1'b0;
    frame_err_d   = rx_err_q;
    guard_load    = 1'b0;
    if (rx_stb_q) begin
      if (!rx_rs_q) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = rx_byte_q;
        param_idx_d = '0;
        pcnt_d      = '0;
        phase_d     = 1'b0;
        state_d     = StIdle;
        case (rx_byte_q)
          8'h2C: begin
            state_d = StRamwr;
            cx_d    = xs_q;
            cy_d    = ys_q;
          end
          8'h2A, 8'h2B: state_d = StParam;
          8'h01: begin
            xs_d = '0; xe_d = XeRst; ys_d = '0; ye_d = YeRst;
            cx_d = '0; cy_d = '0;
            b1_d = '0;
            sleep_d = 1'b0; disp_d = 1'b0; inv_d = 1'b0;
            guard_load = 1'b1;
          end
          8'h11: begin
            sleep_d    = 1'b1;
            guard_load = 1'b1;
          end
          8'h10: sleep_d = 1'b0;
          8'h29: disp_d = 1'b1;
          8'h28: disp_d = 1'b0;
          8'h21: inv_d = 1'b1;
          8'h20: inv_d = 1'b0;
          default: ;
        endcase
      end else if (state_q == StRamwr) begin
        if (!phase_q) begin
          px_data_d[15:8] = rx_byte_q;
          phase_d         = 1'b1;
        end else begin
          px_data_d[7:0] = rx_byte_q;
          phase_d        = 1'b0;
          if (xs_q > xe_q || ys_q > ye_q) begin
            frame_err_d = 1'b1;
          end else begin
            px_valid_d = 1'b1;
            px_x_d     = cx_q;
            px_y_d     = cy_q;
            if (cx_q == xe_q) begin
              cx_d = xs_q;
              cy_d = (cy_q == ye_q) ? ys_q : cy_q + 8'd1;
            end else begin
              cx_d = cx_q + 8'd1;
            end
          end
        end
      end else begin
        param_valid_d = 1'b1;
        param_data_d  = rx_byte_q;
        param_idx_d   = pcnt_q;
        if (pcnt_q != 3'd7) pcnt_d = pcnt_q + 3'd1;
        if (state_q == StParam) begin
          if (pcnt_q == 3'd1) b1_d = rx_byte_q;
          // Only the low byte of each 16-bit coordinate is kept.
          if (pcnt_q == 3'd3) begin
            if (cmd_code_q == 8'h2A) begin
              xs_d = b1_q;
              xe_d = rx_byte_q;
            end else begin
              ys_d = b1_q;
              ye_d = rx_byte_q;
            end
          end
        end
      end
    end
  end

`ifdef ST7789_TIMING_CHK_EN
  // Guard counter: reloads on SWRESET/SLPOUT, flags any byte landing while it runs.
  always_comb begin
    guard_d      = (guard_q != 16'd0) ? guard_q - 16'd1 : 16'd0;
    timing_err_d = rx_stb_q & (guard_q != 16'd0);
    if (guard_load) guard_d = 16'(GUARD_CYCLES);
  end

  // Guard counter and timing_err registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      guard_q      <= '0;
      timing_err_q <= 1'b0;
    end else begin
      guard_q      <= guard_d;
      timing_err_q <= timing_err_d;
    end
  end

  assign timing_err = timing_err_q;
`endif

  // Decoder state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cmd_code_q <= '0; param_data_q <= '0; param_idx_q <= '0; pcnt_q <= '0; b1_q <= '0;
      xs_q <= '0; xe_q <= XeRst; ys_q <= '0; ye_q <= YeRst;
      cx_q <= '0; cy_q <= '0; px_x_q <= '0; px_y_q <= '0; px_data_q <= '0;
      phase_q <= 1'b0; sleep_q <= 1'b0; disp_q <= 1'b0; inv_q <= 1'b0;
      cmd_valid_q <= 1'b0; param_valid_q <= 1'b0; px_valid_q <= 1'b0; frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_code_q <= cmd_code_d; param_data_q <= param_data_d; param_idx_q <= param_idx_d;
      pcnt_q <= pcnt_d; b1_q <= b1_d;
      xs_q <= xs_d; xe_q <= xe_d; ys_q <= ys_d; ye_q <= ye_d;
      cx_q <= cx_d; cy_q <= cy_d; px_x_q <= px_x_d; px_y_q <= px_y_d; px_data_q <= px_data_d;
      phase_q <= phase_d; sleep_q <= sleep_d; disp_q <= disp_d; inv_q <= inv_d;
      cmd_valid_q <= cmd_valid_d; param_valid_q <= param_valid_d;
      px_valid_q <= px_valid_d; frame_err_q <= frame_err_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign param_valid = param_valid_q;
  assign param_data  = param_data_q;
  assign param_idx   = param_idx_q;
  assign px_valid    = px_valid_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign px_data     = px_data_q;
  assign sleep_out   = sleep_q;
  assign disp_on     = disp_q;
  assign inv_on      = inv_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_st7789_spi_responder.sv
// Directed testbench for st7789_spi_responder: bit-bangs the 4-wire bus and
// checks decoded commands, panel state, pixel addressing and error pulses.
module tb_st7789_spi_responder;

  localparam int SYNC = 2;
  localparam int HALF = 2;  // SCL half period in clk cycles
  localparam int LAT  = SYNC + 2;

  logic clk = 1'b0, rst = 1'b0;
  logic lcd_cs = 1'b1, lcd_scl = 1'b0, lcd_sd = 1'b0, lcd_rs = 1'b0;
  logic cmd_valid, param_valid, px_valid, sleep_out, disp_on, inv_on, frame_err;
  logic [7:0] cmd_code, param_data, px_x, px_y;
  logic [2:0] param_idx;
  logic [15:0] px_data;
`ifdef ST7789_TIMING_CHK_EN
  logic timing_err;
`endif

  int tests = 0, fails = 0;
  int n_cmd = 0, n_param = 0, n_px = 0, n_ferr = 0, n_terr = 0;
  logic [7:0]  qx[$], qy[$];
  logic [15:0] qd[$];

  st7789_spi_responder #(
    .DISP_WIDTH(135), .DISP_HEIGHT(240), .SYNC_STAGES(SYNC), .GUARD_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst), .lcd_cs(lcd_cs), .lcd_scl(lcd_scl), .lcd_sd(lcd_sd),
    .lcd_rs(lcd_rs), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .param_valid(param_valid), .param_data(param_data), .param_idx(param_idx),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_data(px_data),
    .sleep_out(sleep_out), .disp_on(disp_on), .inv_on(inv_on),
`ifdef ST7789_TIMING_CHK_EN
    .timing_err(timing_err),
`endif
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmd_valid) n_cmd++;
    if (param_valid) n_param++;
    if (frame_err) n_ferr++;
`ifdef ST7789_TIMING_CHK_EN
    if (timing_err) n_terr++;
`endif
    if (px_valid) begin
      n_px++;
      qx.push_back(px_x);
      qy.push_back(px_y);
      qd.push_back(px_data);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; lcd_cs = 1'b1; lcd_scl = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(SYNC + 3);
  endtask

  task automatic cs_low();
    @(negedge clk);
    lcd_cs = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(2);
    lcd_cs = 1'b1;
    wait_clk(6);
  endtask

  // Ends on the falling edge HALF cycles after the last SCL rise.
  task automatic send_bits(input logic [7:0] b, input int nbits, input logic rs);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      lcd_scl = 1'b0; lcd_sd = b[7-i]; lcd_rs = rs;
      wait_clk(HALF);
      lcd_scl = 1'b1;
      wait_clk(HALF - 1);
    end
    @(negedge clk);
    lcd_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rs);
    send_bits(b, 8, rs);
  endtask

  task automatic send_px(input logic [15:0] d);
    send_byte(d[15:8], 1'b1);
    send_byte(d[7:0], 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({cmd_valid, param_valid, px_valid, frame_err} !== 4'b0) begin
      $display("FAIL reset_pulses got %b want 0000", {cmd_valid, param_valid, px_valid, frame_err});
      fails++;
    end
    tests++;
    if ({sleep_out, disp_on, inv_on} !== 3'b0) begin
      $display("FAIL reset_state got %b want 000", {sleep_out, disp_on, inv_on});
      fails++;
    end
    tests++;
    if ({cmd_code, param_data, param_idx, px_x, px_y, px_data} !== 51'b0) begin
      $display("FAIL reset_regs got %h want 0", {cmd_code, param_data, param_idx, px_x, px_y, px_data});
      fails++;
    end
  endtask

  task automatic test_slpout();
    int c0;
    c0 = n_cmd;
    cs_low();
    send_byte(8'h11, 1'b0);
    // HALF cycles of the LAT latency have already elapsed.
    wait_clk(LAT - HALF - 1);
    tests++;
    if (sleep_out !== 1'b0) begin
      $display("FAIL slpout_early got %b want 0", sleep_out);
      fails++;
    end
    wait_clk(1);
    tests++;
    if (sleep_out !== 1'b1) begin
      $display("FAIL slpout_latency got %b want 1", sleep_out);
      fails++;
    end
    wait_clk(2);
    tests++;
    if (n_cmd - c0 !== 1 || cmd_code !== 8'h11) begin
      $display("FAIL slpout_cmd got n=%0d code=%h want n=1 code=11", n_cmd - c0, cmd_code);
      fails++;
    end
  endtask

  task automatic test_async_reset();
    int c0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if (sleep_out !== 1'b0 || cmd_code !== 8'h00) begin
      $display("FAIL async_reset got sleep=%b code=%h want 0 00", sleep_out, cmd_code);
      fails++;
    end
    wait_clk(2);
    rst = 1'b1;  // CS is still low here
    wait_clk(SYNC + 3);
    c0 = n_cmd;
    send_byte(8'h29, 1'b0);
    wait_clk(LAT + 2);
    tests++;
    if (n_cmd !== c0 || disp_on !== 1'b0) begin
      $display("FAIL async_unarmed got n=%0d disp=%b want 0 0", n_cmd - c0, disp_on);
      fails++;
    end
    cs_high();
    cs_low();
    send_byte(8'h29, 1'b0);
    wait_clk(LAT);
    tests++;
    if (n_cmd - c0 !== 1 || disp_on !== 1'b1) begin
      $display("FAIL async_rearm got n=%0d disp=%b want 1 1", n_cmd - c0, disp_on);
      fails++;
    end
    cs_high();
  endtask

  task automatic test_window_ramwr();
    logic [7:0]  ex[6] = '{8'd5, 8'd6, 8'd5, 8'd6, 8'd5, 8'd6};
    logic [7:0]  ey[6] = '{8'd10, 8'd10, 8'd11, 8'd11, 8'd10, 8'd10};
    logic [15:0] ed[6] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h0000, 16'h1234};
    int p0, f0;
    p0 = n_param; f0 = n_ferr;
    qx.delete(); qy.delete(); qd.delete();
    cs_low();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h06, 1'b1);
    send_byte(8'h2B, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h0B, 1'b1);
    wait_clk(LAT);
    tests++;
    if (param_idx !== 3'd3 || param_data !== 8'h0B) begin
      $display("FAIL raset_last_param got idx=%0d data=%h want 3 0b", param_idx, param_data);
      fails++;
    end
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < 6; i++) send_px(ed[i]);
    wait_clk(LAT + 2);
    cs_high();
    tests++;
    if (n_param - p0 !== 8 || n_ferr !== f0) begin
      $display("FAIL window_params got params=%0d ferr=%0d want 8 0", n_param - p0, n_ferr - f0);
      fails++;
    end
    tests++;
    if (qx.size() !== 6) begin
      $display("FAIL ramwr_count got %0d want 6", qx.size());
      fails++;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (qx[i] !== ex[i] || qy[i] !== ey[i] || qd[i] !== ed[i]) begin
          $display("FAIL ramwr_px%0d got (%0d,%0d,%h) want (%0d,%0d,%h)",
                   i, qx[i], qy[i], qd[i], ex[i], ey[i], ed[i]);
          fails++;
        end
      end
    end
  endtask

  // Streams 137 pixels and checks the default X span 0..135 wraps into row 1.
  task automatic test_default_window(input string tag);
    qx.delete(); qy.delete(); qd.delete();
    cs_low();
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < 137; i++) send_px(16'(i));
    wait_clk(LAT + 2);
    cs_high();
    tests++;
    if (qx.size() !== 137) begin
      $display("FAIL %s_count got %0d want 137", tag, qx.size());
      fails++;
    end else if (qx[0] !== 8'd0 || qy[0] !== 8'd0 || qx[135] !== 8'd135 || qy[135] !== 8'd0
                 || qx[136] !== 8'd0 || qy[136] !== 8'd1 || qd[136] !== 16'd136) begin
      $display("FAIL %s_wrap got (%0d,%0d) (%0d,%0d) (%0d,%0d) want (0,0) (135,0) (0,1)",
               tag, qx[0], qy[0], qx[135], qy[135], qx[136], qy[136]);
      fails++;
    end
  endtask

  task automatic test_truncated_caset();
    int p0;
    do_reset();
    p0 = n_param;
    cs_low();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h09, 1'b1);
    send_byte(8'h29, 1'b0);
    wait_clk(LAT);
    cs_high();
    tests++;
    if (n_param - p0 !== 2 || disp_on !== 1'b1) begin
      $display("FAIL truncated got params=%0d disp=%b want 2 1", n_param - p0, disp_on);
      fails++;
    end
    test_default_window("truncated");
  endtask

  task automatic test_partial_byte();
    int f0, c0;
    cs_low();
    send_byte(8'h28, 1'b0);
    cs_high();
    f0 = n_ferr; c0 = n_cmd;
    cs_low();
    send_bits(8'hA5, 5, 1'b0);
    cs_high();
    tests++;
    if (n_ferr - f0 !== 1 || n_cmd !== c0) begin
      $display("FAIL partial_err got ferr=%0d cmd=%0d want 1 0", n_ferr - f0, n_cmd - c0);
      fails++;
    end
    cs_low();
    send_byte(8'h29, 1'b0);
    wait_clk(LAT);
    cs_high();
    tests++;
    if (cmd_code !== 8'h29 || disp_on !== 1'b1 || n_ferr - f0 !== 1) begin
      $display("FAIL partial_recover got code=%h disp=%b ferr=%0d want 29 1 1",
               cmd_code, disp_on, n_ferr - f0);
      fails++;
    end
  endtask

  task automatic test_cs_simultaneous();
    int f0;
    f0 = n_ferr;
    cs_low();
    send_bits(8'h21, 7, 1'b0);
    @(negedge clk);
    lcd_scl = 1'b0; lcd_sd = 1'b1;
    wait_clk(HALF);
    lcd_scl = 1'b1; lcd_cs = 1'b1;
    wait_clk(LAT + 2);
    lcd_scl = 1'b0;
    wait_clk(4);
    tests++;
    if (inv_on !== 1'b1 || cmd_code !== 8'h21 || n_ferr !== f0) begin
      $display("FAIL cs_simul got inv=%b code=%h ferr=%0d want 1 21 0", inv_on, cmd_code, n_ferr - f0);
      fails++;
    end
  endtask

  task automatic test_drop();
    int f0, x0;
    f0 = n_ferr; x0 = n_px;
    cs_low();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h2C, 1'b0);
    send_px(16'hAAAA);
    send_px(16'h5555);
    send_byte(8'hBB, 1'b1);   // half pixel, then abandoned by a command
    send_byte(8'h00, 1'b0);
    wait_clk(LAT + 2);
    cs_high();
    tests++;
    if (n_ferr - f0 !== 2 || n_px !== x0) begin
      $display("FAIL drop got ferr=%0d px=%0d want 2 0", n_ferr - f0, n_px - x0);
      fails++;
    end
  endtask

  task automatic test_swreset();
    cs_low();
    send_byte(8'h11, 1'b0);
    send_byte(8'h21, 1'b0);
    send_byte(8'h29, 1'b0);
    wait_clk(LAT);
    tests++;
    if ({sleep_out, inv_on, disp_on} !== 3'b111) begin
      $display("FAIL pre_swreset got %b want 111", {sleep_out, inv_on, disp_on});
      fails++;
    end
    send_byte(8'h01, 1'b0);
    wait_clk(LAT);
    cs_high();
    tests++;
    if ({sleep_out, inv_on, disp_on} !== 3'b000 || cmd_code !== 8'h01) begin
      $display("FAIL swreset got %b code=%h want 000 01", {sleep_out, inv_on, disp_on}, cmd_code);
      fails++;
    end
    test_default_window("swreset");  // window was 5..2 before SWRESET
  endtask

`ifdef ST7789_TIMING_CHK_EN
  task automatic test_timing();
    int t0;
    do_reset();
    t0 = n_terr;
    cs_low();
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    wait_clk(LAT + 2);
    tests++;
    if (n_terr - t0 !== 1 || sleep_out !== 1'b1) begin
      $display("FAIL timing_close got terr=%0d sleep=%b want 1 1", n_terr - t0, sleep_out);
      fails++;
    end
    wait_clk(60);
    send_byte(8'h01, 1'b0);
    wait_clk(60);
    t0 = n_terr;
    send_byte(8'h11, 1'b0);
    wait_clk(LAT + 2);
    cs_high();
    tests++;
    if (n_terr !== t0 || sleep_out !== 1'b1) begin
      $display("FAIL timing_quiet got terr=%0d sleep=%b want 0 1", n_terr - t0, sleep_out);
      fails++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_slpout();
    test_async_reset();
    test_window_ramwr();
    test_truncated_caset();
    test_partial_byte();
    test_cs_simultaneous();
    test_drop();
    test_swreset();
`ifdef ST7789_TIMING_CHK_EN
    test_timing();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout tests=%0d want completion", tests);
    $fatal(1, "timeout");
  end

endmodule
